// File: rtl/adsr_envelope.sv
// ADSR envelope generator: turns a note GATE plus per-phase rate ticks into an amplitude ramp.
// Optional exponential release tail when ADSR_EXP_RELEASE_EN is defined.
module adsr_envelope #(
  parameter int unsigned ENV_W = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk50Mhz,
  input  logic             Reset,
  input  logic             GATE,
  input  logic             TICK_A,
  input  logic             TICK_D,
  input  logic [3:0]       SUST_LVL,
  input  logic             TICK_R,
  output logic [ENV_W-1:0] ENV,
  output logic [2:0]       ENV_PHASE,
  output logic             ENV_ACTIVE,
  output logic             ENV_DONE
);

  localparam int unsigned AW = ENV_W + 1;
  localparam logic [AW-1:0] ENV_MAX = {1'b0, {ENV_W{1'b1}}};
  localparam logic [AW-1:0] STEP_W  = AW'(STEP);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } phase_t;

  phase_t           phase_q;
  phase_t           phase_nxt;
  logic             gate_q;
  logic [ENV_W-1:0] env_nxt;
  logic             done_nxt;
  logic [3:0]       lvl;
  logic [AW-1:0]    env_x;
  logic [AW-1:0]    target;
  logic [AW-1:0]    rel_dec;
  logic             rise;
  logic             fall;
  logic             held;
  logic             transition;

  assign env_x  = {1'b0, ENV};
  assign lvl    = (SUST_LVL < 4'd2) ? 4'd2 : ((SUST_LVL > 4'd12) ? 4'd12 : SUST_LVL);
  assign target = AW'(lvl) << (ENV_W - 4);

  assign rise       = GATE & ~gate_q;
  assign fall       = ~GATE & gate_q;
  assign held       = (phase_q == ATTACK) || (phase_q == DECAY) || (phase_q == SUSTAIN);
  // Any gate edge that moves the phase swallows the tick of the same cycle.
  assign transition = rise | (fall & held);

`ifdef ADSR_EXP_RELEASE_EN
  logic [AW-1:0] env_shr;
  assign env_shr = env_x >> 3;
  assign rel_dec = (env_shr > STEP_W) ? env_shr : STEP_W;
`else
  assign rel_dec = STEP_W;
`endif

  always_ff @(posedge clk50Mhz or posedge Reset) begin
    if (Reset) begin
      phase_q    <= IDLE;
      ENV        <= '0;
      ENV_DONE   <= 1'b0;
      ENV_ACTIVE <= 1'b0;
      gate_q     <= 1'b0;
    end else begin
      phase_q    <= phase_nxt;
      ENV        <= env_nxt;
      ENV_DONE   <= done_nxt;
      ENV_ACTIVE <= (phase_nxt != IDLE);
      gate_q     <= GATE;
    end
  end

  assign ENV_PHASE = phase_q;

  always_comb begin
    phase_nxt = phase_q;
    if (rise) begin
      phase_nxt = ATTACK;
    end else if (fall && held) begin
      phase_nxt = RELEASE;
    end else begin
      unique case (phase_q)
        ATTACK:  if (TICK_A && (env_x >= ENV_MAX - STEP_W)) phase_nxt = DECAY;
        DECAY:   if (TICK_D && (env_x <= target + STEP_W))  phase_nxt = SUSTAIN;
        RELEASE: if (TICK_R && (env_x <= STEP_W))           phase_nxt = IDLE;
        default: phase_nxt = phase_q;
      endcase
    end
  end

  // Envelope datapath and completion pulse; ENV is held across phase transitions.
  always_comb begin
    env_nxt  = ENV;
    done_nxt = 1'b0;
    if (!transition) begin
      unique case (phase_q)
        IDLE: env_nxt = '0;
        ATTACK: begin
          if (TICK_A) begin
            if (env_x >= ENV_MAX - STEP_W) env_nxt = ENV_W'(ENV_MAX);
            else                           env_nxt = ENV_W'(env_x + STEP_W);
          end
        end
        DECAY: begin
          if (TICK_D) begin
            if (env_x <= target + STEP_W) env_nxt = ENV_W'(target);
            else                          env_nxt = ENV_W'(env_x - STEP_W);
          end
        end
        SUSTAIN: env_nxt = ENV_W'(target);
        RELEASE: begin
          if (TICK_R) begin
            if (env_x <= STEP_W) begin
              env_nxt  = '0;
              done_nxt = 1'b1;
            end else if (rel_dec >= env_x) begin
              env_nxt = '0;
            end else begin
              env_nxt = ENV_W'(env_x - rel_dec);
            end
          end
        end
        default: env_nxt = ENV;
      endcase
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed ramps plus randomized gate/tick traffic
// against a cycle-level reference model of the envelope rules.
module tb_adsr_envelope;

  localparam int ENV_W   = 8;
  localparam int STEP    = 1;
  localparam int ENV_MAX = (1 << ENV_W) - 1;

  logic             clk50Mhz = 1'b0;
  logic             Reset;
  logic             GATE;
  logic             TICK_A;
  logic             TICK_D;
  logic [3:0]       SUST_LVL;
  logic             TICK_R;
  logic [ENV_W-1:0] ENV;
  logic [2:0]       ENV_PHASE;
  logic             ENV_ACTIVE;
  logic             ENV_DONE;

  adsr_envelope #(.ENV_W(ENV_W), .STEP(STEP)) dut (
    .clk50Mhz  (clk50Mhz),
    .Reset     (Reset),
    .GATE      (GATE),
    .TICK_A    (TICK_A),
    .TICK_D    (TICK_D),
    .SUST_LVL  (SUST_LVL),
    .TICK_R    (TICK_R),
    .ENV       (ENV),
    .ENV_PHASE (ENV_PHASE),
    .ENV_ACTIVE(ENV_ACTIVE),
    .ENV_DONE  (ENV_DONE)
  );

  always #10 clk50Mhz = ~clk50Mhz;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: phase number 0..4 and amplitude as plain integers.
  int m_ph   = 0;
  int m_env  = 0;
  int m_done = 0;
  int m_gq   = 0;
  int done_seen = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int clamp_target(input int s);
    int l;
    l = (s < 2) ? 2 : ((s > 12) ? 12 : s);
    return l * (1 << (ENV_W - 4));
  endfunction

  function automatic int release_amount(input int e);
`ifdef ADSR_EXP_RELEASE_EN
    return ((e / 8) > STEP) ? (e / 8) : STEP;
`else
    return STEP + 0 * e;
`endif
  endfunction

  // One clock edge of the envelope rules, evaluated on the inputs about to be sampled.
  task automatic model_edge(input int g, input int a, input int d, input int r, input int s);
    int tgt;
    int rise;
    int fall;
    tgt    = clamp_target(s);
    rise   = (g == 1 && m_gq == 0);
    fall   = (g == 0 && m_gq == 1);
    m_done = 0;
    if (rise) begin
      m_ph = 1;
    end else if (fall && m_ph >= 1 && m_ph <= 3) begin
      m_ph = 4;
    end else begin
      case (m_ph)
        0: m_env = 0;
        1: if (a) begin
             if (m_env + STEP >= ENV_MAX) begin m_env = ENV_MAX; m_ph = 2; end
             else m_env = m_env + STEP;
           end
        2: if (d) begin
             if (m_env - STEP <= tgt) begin m_env = tgt; m_ph = 3; end
             else m_env = m_env - STEP;
           end
        3: m_env = tgt;
        4: if (r) begin
             if (m_env <= STEP) begin m_env = 0; m_ph = 0; m_done = 1; end
             else m_env = (m_env - release_amount(m_env) < 0) ? 0 : m_env - release_amount(m_env);
           end
        default: m_ph = 0;
      endcase
    end
    m_gq = g;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".env"},    int'(ENV),        m_env);
    check({tag, ".phase"},  int'(ENV_PHASE),  m_ph);
    check({tag, ".active"}, int'(ENV_ACTIVE), (m_ph != 0) ? 1 : 0);
    check({tag, ".done"},   int'(ENV_DONE),   m_done);
    if (ENV_DONE) done_seen++;
  endtask

  task automatic step(input int g, input int a, input int d, input int r, input int s);
    @(negedge clk50Mhz);
    GATE     = g[0];
    TICK_A   = a[0];
    TICK_D   = d[0];
    TICK_R   = r[0];
    SUST_LVL = s[3:0];
    model_edge(g, a, d, r, s);
    @(posedge clk50Mhz);
    #1;
    compare_all("cyc");
  endtask

  // Asynchronous reset placed between clock edges, checked before the next edge.
  task automatic do_reset(input int hold);
    @(negedge clk50Mhz);
    #3;
    Reset  = 1'b1;
    GATE   = 1'b0;
    TICK_A = 1'b0;
    TICK_D = 1'b0;
    TICK_R = 1'b0;
    m_ph = 0; m_env = 0; m_done = 0; m_gq = 0;
    #1;
    compare_all("rst_async");
    repeat (hold) @(posedge clk50Mhz);
    #1;
    compare_all("rst_hold");
    @(negedge clk50Mhz);
    Reset = 1'b0;
  endtask

  int cnt;
  int sl;
  int g;

  initial begin
    Reset = 1'b1; GATE = 1'b0; TICK_A = 1'b0; TICK_D = 1'b0; TICK_R = 1'b0; SUST_LVL = 4'd6;
    #1;
    compare_all("por");
    @(negedge clk50Mhz);
    Reset = 1'b0;

    // Reset mid-attack at ENV=40.
    step(1, 0, 0, 0, 6);
    for (int i = 0; i < 500 && m_env < 40; i++) step(1, 1, 0, 0, 6);
    check("pre_rst_env", int'(ENV), 40);
    do_reset(3);

    // Attack with a tick every 4 clocks.
    step(1, 0, 0, 0, 6);
    check("att_first_phase", int'(ENV_PHASE), 1);
    check("att_first_env", int'(ENV), 0);
    cnt = 0;
    for (int i = 0; i < 4000 && m_ph == 1; i++) begin
      step(1, (i % 4 == 3) ? 1 : 0, 0, 0, 6);
      if (i % 4 == 3) cnt++;
    end
    check("att_ticks", cnt, 255);
    check("att_top_env", int'(ENV), 255);
    check("att_top_phase", int'(ENV_PHASE), 2);

    // Decay to sustain level 6, then follow level changes.
    cnt = 0;
    for (int i = 0; i < 2000 && m_ph == 2; i++) begin
      step(1, 1, (i % 2) ? 1 : 0, 1, 6);
      if (i % 2) cnt++;
    end
    check("dec_ticks", cnt, 159);
    check("dec_env", int'(ENV), 96);
    check("dec_phase", int'(ENV_PHASE), 3);
    step(1, 1, 1, 1, 8);
    check("sus_lvl8", int'(ENV), 128);
    step(1, 0, 0, 0, 0);
    check("sus_lvl0", int'(ENV), 32);
    step(1, 0, 0, 0, 15);
    check("sus_lvl15", int'(ENV), 192);
    step(1, 0, 0, 0, 8);
    check("sus_back8", int'(ENV), 128);

    // Release from 128 to zero.
    step(0, 0, 0, 1, 8);
    check("rel_phase", int'(ENV_PHASE), 4);
    check("rel_env_kept", int'(ENV), 128);
    done_seen = 0;
    cnt = 0;
    for (int i = 0; i < 3000 && m_ph == 4; i++) begin
      step(0, 0, 0, (i % 3 == 0) ? 1 : 0, 8);
      if (i % 3 == 0) cnt++;
      if (cnt == 1 && i == 0) begin
`ifdef ADSR_EXP_RELEASE_EN
        check("rel_first", int'(ENV), 112);
`else
        check("rel_first", int'(ENV), 127);
`endif
      end
    end
`ifndef ADSR_EXP_RELEASE_EN
    check("rel_ticks", cnt, 128);
`endif
    check("rel_end_env", int'(ENV), 0);
    check("rel_end_phase", int'(ENV_PHASE), 0);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 8);
    check("done_pulses", done_seen, 1);
    check("idle_env", int'(ENV), 0);

    // Retrigger from release at 50, then a fall coincident with TICK_A at 70.
    step(1, 0, 0, 0, 8);
    for (int i = 0; i < 500 && m_env < 60; i++) step(1, 1, 0, 0, 8);
    step(0, 0, 0, 0, 8);
    for (int i = 0; i < 500 && m_env > 50; i++) step(0, 0, 0, 1, 8);
    check("rt_pre_env", int'(ENV), 50);
    step(1, 1, 1, 1, 8);
    check("rt_phase", int'(ENV_PHASE), 1);
    check("rt_env", int'(ENV), 50);
    step(1, 1, 0, 0, 8);
    check("rt_next", int'(ENV), 51);
    for (int i = 0; i < 500 && m_env < 70; i++) step(1, 1, 0, 0, 8);
    step(0, 1, 0, 0, 8);
    check("fall_tick_phase", int'(ENV_PHASE), 4);
    check("fall_tick_env", int'(ENV), 70);

    // Randomized traffic with occasional resets.
    g  = 0;
    sl = 6;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 63) == 0) g = 1 - g;
      if ($urandom_range(0, 49) == 0) sl = int'($urandom_range(0, 15));
      if ($urandom_range(0, 2999) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
        g = 0;
      end else begin
        step(g, ($urandom_range(0, 2) == 0) ? 1 : 0, ($urandom_range(0, 2) == 0) ? 1 : 0,
             ($urandom_range(0, 2) == 0) ? 1 : 0, sl);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
Envelope generator that consumes the per-phase rate ticks and sustain level produced by the ADSR clock divider, and turns a note GATE into an amplitude envelope. It sits between the ADSR clock divider and the output amplitude multiplier of each voice.
- State machine: IDLE/ATTACK/DECAY/SUSTAIN/RELEASE.
- ENV steps by STEP on each qualifying tick.

Parameters:
ENV_W, 8, envelope width; ENV_MAX = 2^ENV_W-1
STEP, 1, linear increment/decrement per tick (1..ENV_MAX)

Ports:
clk50Mhz  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high; clears all state immediately
GATE  input  1  note on (1) / off (0), synchronous to clk50Mhz
TICK_A  input  1  attack rate tick, one-cycle pulse
TICK_D  input  1  decay rate tick, one-cycle pulse
SUST_LVL  input  4  sustain level, legal range 2..12
TICK_R  input  1  release rate tick, one-cycle pulse
ENV  output  ENV_W  envelope amplitude, registered
ENV_PHASE  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
ENV_ACTIVE  output  1  high whenever ENV_PHASE != IDLE
ENV_DONE  output  1  one-cycle pulse when RELEASE reaches 0

Behaviour:
- Reset asserted: ENV=0, ENV_PHASE=IDLE, ENV_ACTIVE=0, ENV_DONE=0, gate_q=0, all asynchronously. Mid-operation reset aborts the envelope with no ramp.
- gate_q holds GATE registered.
- rise = GATE & ~gate_q; fall = ~GATE & gate_q. Transitions take effect on the same edge (0 cycles of latency from sampled GATE).
- Clamping and target:
  - lvl = SUST_LVL clamped to 2..12.
  - target = lvl << (ENV_W-4), e.g. 96 for lvl=6 with ENV_W=8.
- Priority on each edge: rise > fall > tick processing. A tick that coincides with a transition is ignored; ENV is unchanged that edge.
- rise in any state (including RELEASE and DECAY) -> ATTACK, with ENV kept (retrigger, no click).
- fall in ATTACK/DECAY/SUSTAIN -> RELEASE, with ENV kept.
- IDLE: ENV=0 and all ticks are ignored.
- ATTACK, on TICK_A:
  - If ENV >= ENV_MAX-STEP: ENV=ENV_MAX and the state moves to DECAY on that edge.
  - Otherwise ENV += STEP.
- DECAY, on TICK_D:
  - If ENV <= target+STEP: ENV=target -> SUSTAIN.
  - Otherwise ENV -= STEP.
  - If ENV <= target on entry, the first TICK_D lands on target.
- SUSTAIN: ENV = target every cycle, so it follows SUST_LVL changes one edge later. Ticks are ignored.
- RELEASE, on TICK_R:
  - If ENV <= STEP: ENV=0, state -> IDLE, and ENV_DONE=1 for one cycle.
  - Otherwise ENV -= STEP.
- ENV_DONE is otherwise 0. Reaching IDLE never occurs by any other path except Reset, which does not pulse ENV_DONE.
- Arithmetic is ENV_W+1 bits internally. ENV never wraps; it saturates at 0 and ENV_MAX.
- Multiple ticks asserted together: only the tick of the current phase is used.

Optional Feature:
ADSR_EXP_RELEASE_EN:
- Defined: in RELEASE, the decrement per TICK_R is max(ENV>>3, STEP), giving an exponential-style tail. The terminal condition (ENV <= STEP -> 0, IDLE, ENV_DONE) is unchanged.
- Undefined: linear release by STEP. All other phases are linear in both builds.

Test Plan:
1. Pulse Reset mid-attack with ENV=40 -> ENV=0, ENV_PHASE=0, ENV_ACTIVE=0 before the next clock edge. These outputs hold while Reset=1.
2. GATE=1 with TICK_A every 4 clocks (ENV_W=8, STEP=1):
   - ENV_PHASE=1 on the first edge, with ENV=0.
   - After 255 ticks, ENV=255 and ENV_PHASE=2 on the same edge.
3. SUST_LVL=6 in DECAY -> 159 TICK_D bring ENV to 96 with ENV_PHASE=3.
   - Change SUST_LVL to 8 -> ENV=128 one edge later.
   - SUST_LVL=0 -> 32; SUST_LVL=15 -> 192.
4. At SUSTAIN ENV=128, drop GATE -> ENV_PHASE=4.
   - 128 TICK_R -> ENV=0, ENV_PHASE=0, ENV_DONE high for exactly 1 cycle.
   - Ticks afterwards leave ENV at 0.
5. Retrigger in RELEASE at ENV=50 by raising GATE -> ENV_PHASE=1, ENV=50; the next TICK_A gives 51.
   - GATE fall coincident with TICK_A at ENV=70 -> RELEASE, ENV stays 70.
6. With ADSR_EXP_RELEASE_EN defined, release from 128 -> ENV 112, 98, 86, ... down to 0 with ENV_DONE. Without the macro -> 127, 126, ...
